ysyx_040750_npc_gen: RTL

Parametrised next-PC generator between the redirect sources (branch/jump resolve, CSR trap/mret, fence.i) and the instruction-fetch request port. It keeps the current fetch PC, advances it sequentially on every accepted fetch, and arbitrates up to NCH redirect channels by fixed priority. A redirect that arrives while fetch is stalled is held until fetch accepts it. An epoch counter tags every issued PC so that downstream stages can drop wrong-path fetches. A BYPASS mode selects between a same-cycle redirect and a registered redirect.

---
 rtl/ysyx_040750_npc_gen_if.sv | 25 ++
 rtl/ysyx_040750_npc_gen.sv | 55 +++++
 2 files changed

// File: rtl/ysyx_040750_npc_gen_if.sv
// ysyx_040750_npc_gen_if: redirect channels plus fetch request port of the next-PC generator
interface ysyx_040750_npc_gen_if #(
   parameter int XLEN    = 32,
   parameter int NCH     = 4,
   parameter int EPOCH_W = 2
);
   logic [NCH-1:0]      I_redir_valid;
   logic [NCH*XLEN-1:0] I_redir_base;
   logic [NCH*XLEN-1:0] I_redir_off;
   logic [NCH-1:0]      I_redir_clr_lsb;
   logic                I_hold;
   logic                I_pc_ready;
   logic                O_pc_valid;
   logic [XLEN-1:0]     O_pc;
   logic [EPOCH_W-1:0]  O_epoch;
   logic [NCH-1:0]      O_redir_taken;
   modport master (
      input  I_redir_valid, I_redir_base, I_redir_off, I_redir_clr_lsb, I_hold, I_pc_ready,
      output O_pc_valid, O_pc, O_epoch, O_redir_taken
   );
   modport slave (
      output I_redir_valid, I_redir_base, I_redir_off, I_redir_clr_lsb, I_hold, I_pc_ready,
      input  O_pc_valid, O_pc, O_epoch, O_redir_taken
   );
endinterface

// File: rtl/ysyx_040750_npc_gen.sv
// ysyx_040750_npc_gen: fetch PC sequencer with fixed-priority redirect arbitration and epoch tagging
module ysyx_040750_npc_gen #(
   parameter int              XLEN    = 32,
   parameter int              NCH     = 4,
   parameter logic [XLEN-1:0] RST_PC  = 32'h8000_0000,
   parameter int              ILEN    = 4,
   parameter int              EPOCH_W = 2,
   parameter bit              BYPASS  = 1'b1
) (
   input logic I_clk,
   input logic I_rst,
   ysyx_040750_npc_gen_if.master bus
);
   logic [XLEN-1:0]    pc_reg, pc_nxt, sum, tgt, seq, tgt_seq;
   logic               vld_reg, pc_valid, hs, r, clr;
   logic [EPOCH_W-1:0] epoch_reg, epoch_inc;
   logic [NCH-1:0]     taken_reg, oh;
   // lowest set bit wins; the rest of the same cycle's requests are dropped
   always_comb begin
      oh  = bus.I_redir_valid & (~bus.I_redir_valid + NCH'(1));
      sum = '0;
      clr = 1'b0;
      for (int k = 0; k < NCH; k++)
         if (oh[k]) begin
            sum = bus.I_redir_base[k*XLEN +: XLEN] + bus.I_redir_off[k*XLEN +: XLEN];
            clr = bus.I_redir_clr_lsb[k];
         end
   end
   assign r         = |bus.I_redir_valid;
   assign tgt       = {sum[XLEN-1:1], sum[0] & ~clr};
   assign seq       = pc_reg + XLEN'(ILEN);
   assign tgt_seq   = tgt + XLEN'(ILEN);
   assign epoch_inc = epoch_reg + EPOCH_W'(1);
   assign pc_valid  = vld_reg & ~bus.I_hold;
   assign hs        = pc_valid & bus.I_pc_ready;
   // with bypass the target itself is offered now, so a handshake consumes it
   assign pc_nxt = r ? ((BYPASS && hs) ? tgt_seq : tgt) : (hs ? seq : pc_reg);
   assign bus.O_pc_valid    = pc_valid;
   assign bus.O_pc          = (BYPASS && r) ? tgt : pc_reg;
   assign bus.O_epoch       = (BYPASS && r) ? epoch_inc : epoch_reg;
   assign bus.O_redir_taken = taken_reg;
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         pc_reg    <= RST_PC;
         vld_reg   <= 1'b0;
         epoch_reg <= '0;
         taken_reg <= '0;
      end else begin
         pc_reg    <= pc_nxt;
         vld_reg   <= 1'b1;
         epoch_reg <= r ? epoch_inc : epoch_reg;
         taken_reg <= oh;
      end
   end
endmodule
